// File: rtl/branch_resolution_unit_pkg.sv
// Shared definitions for the execute-stage branch resolver and its BTB.
package branch_resolution_unit_pkg;

    // funct3 encodings of the conditional branches
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // 2-bit saturating direction counter; bit 1 is the predicted direction
    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_e;

    // Widest tag needed (index width 0); narrower tags are zero-extended
    localparam int unsigned TAG_MAX_W = 30;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        ctr_e                 ctr;
    } btb_entry_t;

    function automatic logic [TAG_MAX_W-1:0] pc_tag(input logic [31:0] pc,
                                                    input int unsigned idx_w);
        return TAG_MAX_W'(pc >> (idx_w + 2));
    endfunction

    function automatic ctr_e ctr_step(input ctr_e c, input logic taken);
        ctr_e r;
        r = c;
        case (c)
            STRONG_NT: r = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   r = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    r = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  r = taken ? STRONG_T : WEAK_T;
            default:   r = c;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_resolution_unit_if.sv
// Execute/fetch-side signal bundle of the branch resolution unit.
interface branch_resolution_unit_if;
    logic        Jump_En_E;
    logic        Branch_En_E;
    logic        Branch_Src_Sel_E;
    logic [2:0]  Branch_Cond_E;
    logic        Predict_Taken_E;
    logic [31:0] PC_E;
    logic [31:0] PC_Plus_4_E;
    logic [31:0] Imm_Ext_E;
    logic [31:0] Fwd_Data1_E;
    logic [31:0] Fwd_Data2_E;
    logic [31:0] PC_F;
    logic        Predict_Taken_F;
    logic [31:0] Predict_Target_F;
    logic        Mispredict_E;
    logic [31:0] Redirect_PC_E;
    logic [31:0] Branch_Count;
    logic [31:0] Mispredict_Count;

    modport master (
        output Jump_En_E, Branch_En_E, Branch_Src_Sel_E, Branch_Cond_E,
               Predict_Taken_E, PC_E, PC_Plus_4_E, Imm_Ext_E,
               Fwd_Data1_E, Fwd_Data2_E, PC_F,
        input  Predict_Taken_F, Predict_Target_F, Mispredict_E,
               Redirect_PC_E, Branch_Count, Mispredict_Count
    );

    modport slave (
        input  Jump_En_E, Branch_En_E, Branch_Src_Sel_E, Branch_Cond_E,
               Predict_Taken_E, PC_E, PC_Plus_4_E, Imm_Ext_E,
               Fwd_Data1_E, Fwd_Data2_E, PC_F,
        output Predict_Taken_F, Predict_Target_F, Mispredict_E,
               Redirect_PC_E, Branch_Count, Mispredict_Count
    );
endinterface

// File: rtl/branch_resolution_unit_branch_cond.sv
// funct3 comparator: decides whether a conditional branch is taken.
module branch_cond
    import branch_resolution_unit_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        cond_o
);

    // Compare operands according to funct3; reserved encodings resolve not-taken
    always_comb begin
        cond_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  cond_o = (rs1_i == rs2_i);
            F3_BNE:  cond_o = (rs1_i != rs2_i);
            F3_BLT:  cond_o = ($signed(rs1_i) <  $signed(rs2_i));
            F3_BGE:  cond_o = ($signed(rs1_i) >= $signed(rs2_i));
            F3_BLTU: cond_o = (rs1_i <  rs2_i);
            F3_BGEU: cond_o = (rs1_i >= rs2_i);
            default: cond_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolution_unit.sv
// Execute-stage branch resolver with a direct-mapped 2-bit-counter BTB
// and branch/mispredict performance counters.
module branch_resolution_unit
    import branch_resolution_unit_pkg::*;
#(
    parameter int unsigned BTB_IDX_W = 6
) (
    input logic                     CLK,
    input logic                     RST,
    branch_resolution_unit_if.slave brif
);

    localparam int unsigned ENTRIES = 1 << BTB_IDX_W;

    logic [ENTRIES-1:0]   valid_q;
    logic [TAG_MAX_W-1:0] tag_q    [ENTRIES];
    logic [31:0]          target_q [ENTRIES];
    ctr_e                 ctr_q    [ENTRIES];
    logic [31:0]          branch_cnt_q, branch_cnt_d;
    logic [31:0]          mispred_cnt_q, mispred_cnt_d;

    logic [BTB_IDX_W-1:0] idx_f, idx_e;
    btb_entry_t           rd_f, rd_e, wr_e;
    logic                 hit_f, hit_e;
    logic                 cond, active, is_jalr, taken, to_target, mispredict, upd_e;
    logic [31:0]          sum, target;

    branch_cond u_branch_cond (
        .funct3_i (brif.Branch_Cond_E),
        .rs1_i    (brif.Fwd_Data1_E),
        .rs2_i    (brif.Fwd_Data2_E),
        .cond_o   (cond)
    );

    // Table reads: fetch-side prediction lookup and execute-side training read
    always_comb begin
        idx_f = brif.PC_F[BTB_IDX_W+1:2];
        idx_e = brif.PC_E[BTB_IDX_W+1:2];
        rd_f  = '{valid: valid_q[idx_f], tag: tag_q[idx_f], target: target_q[idx_f], ctr: ctr_q[idx_f]};
        rd_e  = '{valid: valid_q[idx_e], tag: tag_q[idx_e], target: target_q[idx_e], ctr: ctr_q[idx_e]};
        hit_f = rd_f.valid && (rd_f.tag == pc_tag(brif.PC_F, BTB_IDX_W));
        hit_e = rd_e.valid && (rd_e.tag == pc_tag(brif.PC_E, BTB_IDX_W));
        brif.Predict_Taken_F  = hit_f & rd_f.ctr[1];
        brif.Predict_Target_F = hit_f ? rd_f.target : '0;
    end

    // Resolve direction and target, flag mispredictions, build the table write
    always_comb begin
        active     = brif.Branch_En_E | brif.Jump_En_E;
        is_jalr    = active & brif.Branch_Src_Sel_E;
        taken      = brif.Jump_En_E | (brif.Branch_En_E & cond);
        sum        = (brif.Branch_Src_Sel_E ? brif.Fwd_Data1_E : brif.PC_E) + brif.Imm_Ext_E;
        target     = brif.Branch_Src_Sel_E ? {sum[31:1], 1'b0} : sum;
        to_target  = active & (is_jalr | (taken & ~brif.Predict_Taken_E));
        mispredict = ~RST & active & (is_jalr | (taken ^ brif.Predict_Taken_E));
        brif.Mispredict_E  = mispredict;
        brif.Redirect_PC_E = (~RST & to_target) ? target : brif.PC_Plus_4_E;

        upd_e = active & ~brif.Branch_Src_Sel_E & (hit_e | taken);
        wr_e  = rd_e;
        if (hit_e) begin
            wr_e.ctr = ctr_step(rd_e.ctr, taken);
        end else begin
            wr_e = '{valid: 1'b1, tag: pc_tag(brif.PC_E, BTB_IDX_W), target: target, ctr: WEAK_T};
        end

        branch_cnt_d  = branch_cnt_q  + {31'd0, active};
        mispred_cnt_d = mispred_cnt_q + {31'd0, mispredict};
    end

    // Valid bits and counters clear on reset; a reset cycle drops any update
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q       <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (upd_e) begin
                valid_q[idx_e] <= 1'b1;
            end
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Entry payload storage, left unreset since valid gates every use
    always_ff @(posedge CLK) begin
        if (!RST && upd_e) begin
            tag_q[idx_e]    <= wr_e.tag;
            target_q[idx_e] <= wr_e.target;
            ctr_q[idx_e]    <= wr_e.ctr;
        end
    end

    assign brif.Branch_Count     = branch_cnt_q;
    assign brif.Mispredict_Count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Bench for branch_resolution_unit: directed sequences, a funct3 vector
// table and randomized traffic against a behavioural BTB model.
module tb_branch_resolution_unit;

    localparam int IDX_W = 6;
    localparam int N     = 1 << IDX_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_resolution_unit_if bus ();

    branch_resolution_unit #(.BTB_IDX_W(IDX_W)) dut (
        .CLK  (clk),
        .RST  (rst),
        .brif (bus)
    );

    int checks = 0;
    int errors = 0;

    // behavioural model state
    bit          m_valid [N];
    logic [31:0] m_hi    [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    logic [31:0] m_bc, m_mc;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        bit          taken;
    } vec_t;
    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, output bit hit, output int slot);
        slot = int'((pc >> 2) % N);
        hit  = m_valid[slot] && (m_hi[slot] == (pc >> (IDX_W + 2)));
    endfunction

    function automatic void m_eval(output bit active, output bit taken, output bit mis,
                                   output logic [31:0] tgt, output logic [31:0] red);
        active = bus.Branch_En_E || bus.Jump_En_E;
        taken  = bus.Jump_En_E || (bus.Branch_En_E && m_cond(bus.Branch_Cond_E, bus.Fwd_Data1_E, bus.Fwd_Data2_E));
        if (bus.Branch_Src_Sel_E) tgt = (bus.Fwd_Data1_E + bus.Imm_Ext_E) & ~32'd1;
        else                      tgt = bus.PC_E + bus.Imm_Ext_E;
        mis = 1'b0;
        red = bus.PC_Plus_4_E;
        if (!rst && active) begin
            if (bus.Branch_Src_Sel_E || (taken && !bus.Predict_Taken_E)) begin
                mis = 1'b1;
                red = tgt;
            end else if (!taken && bus.Predict_Taken_E) begin
                mis = 1'b1;
            end
        end
    endfunction

    function automatic bit m_predict(input logic [31:0] pc);
        bit hit;
        int s;
        m_lookup(pc, hit, s);
        return hit && (m_ctr[s] >= 2);
    endfunction

    // Compare every output against the model with inputs settled
    task automatic settle(input string tag);
        bit active, taken, mis, hit;
        int s;
        logic [31:0] tgt, red;
        #1;
        m_eval(active, taken, mis, tgt, red);
        m_lookup(bus.PC_F, hit, s);
        chk({tag, ".mispredict"}, {31'd0, bus.Mispredict_E}, {31'd0, mis});
        chk({tag, ".redirect"}, bus.Redirect_PC_E, red);
        chk({tag, ".pred_taken_f"}, {31'd0, bus.Predict_Taken_F}, {31'd0, hit && m_ctr[s] >= 2});
        chk({tag, ".pred_target_f"}, bus.Predict_Target_F, hit ? m_tgt[s] : 32'd0);
        chk({tag, ".branch_count"}, bus.Branch_Count, m_bc);
        chk({tag, ".mispredict_count"}, bus.Mispredict_Count, m_mc);
    endtask

    // Advance one clock and apply the same edge to the model
    task automatic clock();
        bit active, taken, mis, hit;
        int s;
        logic [31:0] tgt, red;
        m_eval(active, taken, mis, tgt, red);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
            m_bc = 0;
            m_mc = 0;
        end else begin
            if (active) m_bc++;
            if (mis) m_mc++;
            if (active && !bus.Branch_Src_Sel_E) begin
                m_lookup(bus.PC_E, hit, s);
                if (hit) begin
                    m_ctr[s] = taken ? ((m_ctr[s] == 3) ? 3 : m_ctr[s] + 1)
                                     : ((m_ctr[s] == 0) ? 0 : m_ctr[s] - 1);
                end else if (taken) begin
                    m_valid[s] = 1'b1;
                    m_hi[s]    = bus.PC_E >> (IDX_W + 2);
                    m_tgt[s]   = tgt;
                    m_ctr[s]   = 2;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.Jump_En_E = 0; bus.Branch_En_E = 0; bus.Branch_Src_Sel_E = 0;
        bus.Branch_Cond_E = 0; bus.Predict_Taken_E = 0;
        bus.PC_E = 0; bus.PC_Plus_4_E = 4; bus.Imm_Ext_E = 0;
        bus.Fwd_Data1_E = 0; bus.Fwd_Data2_E = 0;
    endtask

    task automatic beq(input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] a, input logic [31:0] b, input bit pred);
        idle();
        bus.Branch_En_E = 1; bus.Branch_Cond_E = 3'b000;
        bus.PC_E = pc; bus.PC_Plus_4_E = pc + 4; bus.Imm_Ext_E = imm;
        bus.Fwd_Data1_E = a; bus.Fwd_Data2_E = b; bus.Predict_Taken_E = pred;
    endtask

    initial begin
        vecs[0]  = '{3'b000, 32'd5,        32'd5,        1'b1};
        vecs[1]  = '{3'b000, 32'd5,        32'd6,        1'b0};
        vecs[2]  = '{3'b001, 32'd5,        32'd6,        1'b1};
        vecs[3]  = '{3'b001, 32'd7,        32'd7,        1'b0};
        vecs[4]  = '{3'b100, 32'hFFFFFFFF, 32'd1,        1'b1};
        vecs[5]  = '{3'b100, 32'd1,        32'hFFFFFFFF, 1'b0};
        vecs[6]  = '{3'b101, 32'hFFFFFFFF, 32'd1,        1'b0};
        vecs[7]  = '{3'b101, 32'd3,        32'd3,        1'b1};
        vecs[8]  = '{3'b110, 32'hFFFFFFFF, 32'd1,        1'b0};
        vecs[9]  = '{3'b110, 32'd1,        32'hFFFFFFFF, 1'b1};
        vecs[10] = '{3'b111, 32'd1,        32'd1,        1'b1};
        vecs[11] = '{3'b111, 32'd0,        32'd1,        1'b0};
        vecs[12] = '{3'b010, 32'd1,        32'd1,        1'b0};
        vecs[13] = '{3'b011, 32'd0,        32'd1,        1'b0};

        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0; m_hi[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
        end
        m_bc = 0; m_mc = 0;
        idle();
        bus.PC_F = 32'h100;
        rst = 1'b1;
        @(negedge clk);
        clock();
        clock();
        rst = 1'b0;

        // reset state
        settle("reset");
        chk("reset_pred_f", {31'd0, bus.Predict_Taken_F}, 32'd0);
        chk("reset_bc", bus.Branch_Count, 32'd0);
        chk("reset_mc", bus.Mispredict_Count, 32'd0);
        clock();

        // taken BEQ allocates
        beq(32'h100, 32'h40, 32'd5, 32'd5, 1'b0);
        settle("beq_alloc");
        chk("beq_alloc_mis", {31'd0, bus.Mispredict_E}, 32'd1);
        chk("beq_alloc_red", bus.Redirect_PC_E, 32'h140);
        clock();
        idle();
        bus.PC_F = 32'h100;
        settle("lookup_after_alloc");
        chk("alloc_pred_f", {31'd0, bus.Predict_Taken_F}, 32'd1);
        chk("alloc_target_f", bus.Predict_Target_F, 32'h140);

        // three not-taken executions walk the counter down and saturate
        for (int k = 0; k < 3; k++) begin
            bus.PC_F = 32'h100;
            #1;
            beq(32'h100, 32'h40, 32'd5, 32'd6, bus.Predict_Taken_F);
            settle("beq_nt");
            chk($sformatf("beq_nt%0d_mis", k), {31'd0, bus.Mispredict_E}, (k == 0) ? 32'd1 : 32'd0);
            chk($sformatf("beq_nt%0d_red", k), bus.Redirect_PC_E, 32'h104);
            clock();
        end
        chk("nt_mc", bus.Mispredict_Count, 32'd2);
        // counter at 00: one taken moves it only to 01, so still not-taken
        bus.PC_F = 32'h100;
        #1;
        beq(32'h100, 32'h40, 32'd9, 32'd9, bus.Predict_Taken_F);
        settle("beq_t_after_sat");
        chk("sat_mis", {31'd0, bus.Mispredict_E}, 32'd1);
        clock();
        idle();
        bus.PC_F = 32'h100;
        settle("sat_lookup");
        chk("sat_pred_f", {31'd0, bus.Predict_Taken_F}, 32'd0);
        chk("sat_target_f", bus.Predict_Target_F, 32'h140);
        chk("sat_bc", bus.Branch_Count, 32'd5);

        // JALR: always redirects, never written
        idle();
        bus.Jump_En_E = 1; bus.Branch_Src_Sel_E = 1;
        bus.PC_E = 32'h400; bus.PC_Plus_4_E = 32'h404;
        bus.Fwd_Data1_E = 32'h2003; bus.Imm_Ext_E = 32'd4;
        settle("jalr");
        chk("jalr_mis", {31'd0, bus.Mispredict_E}, 32'd1);
        chk("jalr_red", bus.Redirect_PC_E, 32'h2006);
        clock();
        idle();
        bus.PC_F = 32'h400;
        settle("jalr_lookup");
        chk("jalr_no_alloc", bus.Predict_Target_F, 32'd0);

        // bubble with stale prediction
        idle();
        bus.Predict_Taken_E = 1;
        bus.PC_E = 32'h100; bus.PC_Plus_4_E = 32'h104;
        settle("bubble");
        chk("bubble_mis", {31'd0, bus.Mispredict_E}, 32'd0);
        clock();
        chk("bubble_bc", bus.Branch_Count, 32'd6);
        chk("bubble_mc", bus.Mispredict_Count, 32'd4);

        // aliasing: 0x300 evicts 0x100 at index 0
        beq(32'h300, 32'h20, 32'd1, 32'd1, 1'b0);
        settle("alias");
        clock();
        idle();
        bus.PC_F = 32'h100;
        settle("alias_old");
        chk("alias_old_target", bus.Predict_Target_F, 32'd0);
        bus.PC_F = 32'h300;
        settle("alias_new");
        chk("alias_new_pred", {31'd0, bus.Predict_Taken_F}, 32'd1);
        chk("alias_new_target", bus.Predict_Target_F, 32'h320);

        // reset in the middle of a branch drops its update
        beq(32'h180, 32'h10, 32'd2, 32'd2, 1'b0);
        bus.PC_F = 32'h180;
        rst = 1'b1;
        settle("rst_branch");
        chk("rst_branch_mis", {31'd0, bus.Mispredict_E}, 32'd0);
        clock();
        rst = 1'b0;
        idle();
        bus.PC_F = 32'h180;
        settle("after_rst");
        chk("after_rst_target", bus.Predict_Target_F, 32'd0);
        chk("after_rst_bc", bus.Branch_Count, 32'd0);
        chk("after_rst_mc", bus.Mispredict_Count, 32'd0);
        bus.PC_F = 32'h300;
        settle("after_rst_300");
        chk("after_rst_300_pred", {31'd0, bus.Predict_Taken_F}, 32'd0);
        clock();

        // funct3 vector table
        for (int i = 0; i < 14; i++) begin
            idle();
            bus.Branch_En_E = 1; bus.Branch_Cond_E = vecs[i].f3;
            bus.PC_E = 32'h1000 + 32'(i * 8); bus.PC_Plus_4_E = bus.PC_E + 4;
            bus.Imm_Ext_E = 32'h10;
            bus.Fwd_Data1_E = vecs[i].a; bus.Fwd_Data2_E = vecs[i].b;
            settle("vec");
            chk($sformatf("vec%0d_mis", i), {31'd0, bus.Mispredict_E}, {31'd0, vecs[i].taken});
            chk($sformatf("vec%0d_red", i), bus.Redirect_PC_E,
                vecs[i].taken ? bus.PC_E + 32'h10 : bus.PC_E + 4);
            clock();
        end

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int kind;
            idle();
            kind = $urandom_range(0, 3);
            bus.Branch_En_E      = (kind == 1);
            bus.Jump_En_E        = (kind >= 2);
            bus.Branch_Src_Sel_E = (kind == 3);
            bus.Branch_Cond_E    = 3'($urandom_range(0, 7));
            bus.PC_E        = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 8);
            bus.PC_Plus_4_E = bus.PC_E + 4;
            bus.PC_F        = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 8);
            bus.Imm_Ext_E   = $urandom;
            bus.Fwd_Data1_E = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
            bus.Fwd_Data2_E = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
            bus.Predict_Taken_E = $urandom_range(0, 1) ? m_predict(bus.PC_E) : 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 63) == 0);
            settle("rand");
            clock();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
